// File: rtl/bb_sym_chk.sv
// ============================================================================
// bb_sym_chk : baseband test-symbol checker (LFSR reference, lock FSM,
//              saturating counters). Optional capture: BB_SYM_CHK_FIRST_ERR_EN
// Revision   : 1.0
// ============================================================================
`default_nettype none

module bb_sym_chk #(
  parameter logic [15:0] LOCK_NUM  = 16'd64,
  parameter logic [15:0] LOSS_NUM  = 16'd8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic [9:0]           bb_sym_iq,
  input  logic                 bb_sym_vi,
  input  logic                 clr,
  output logic                 chk_lock,
  output logic                 chk_err,
  output logic [1:0]           chk_state,
`ifdef BB_SYM_CHK_FIRST_ERR_EN
  output logic                 first_err_vld,
  output logic [9:0]           first_err_got,
  output logic [9:0]           first_err_exp,
  output logic [CNT_WIDTH-1:0] first_err_idx,
`endif
  output logic [CNT_WIDTH-1:0] sym_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [39:0]          C_LFSR_SEED = '1;
  localparam logic [39:0]          C_LFSR_MASK = 40'h7F_FFFF_FFBB;
  localparam logic [9:0]           C_FORCED    = 10'h021;
  localparam logic [15:0]          C_RUN_MAX   = 16'hFFFF;
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q;
  logic [39:0]            ref_q, ref_d;
  logic [15:0]            good_q, good_d, bad_q, bad_d;
  logic [CNT_WIDTH-1:0]   sym_cnt_q, sym_cnt_d, err_cnt_q, err_cnt_d;
  logic                   lock_q, err_q;
  logic [9:0]             exp_sym;
  logic                   sym_match, sym_bad;

  assign exp_sym   = ref_q[9:0] | C_FORCED;
  assign sym_match = (bb_sym_iq == exp_sym);
  assign sym_bad   = bb_sym_vi & ~sym_match;

  // Any invalid cycle reseeds the reference and clears both runs.
  always_comb begin
    ref_d  = C_LFSR_SEED;
    good_d = '0;
    bad_d  = '0;
    if (bb_sym_vi) begin
      ref_d = (ref_q & C_LFSR_MASK) ^ (ref_q << 1) ^ (ref_q >> 1);
      if (sym_match) begin
        good_d = (good_q == C_RUN_MAX) ? good_q : good_q + 16'd1;
      end else begin
        bad_d  = (bad_q == C_RUN_MAX) ? bad_q : bad_q + 16'd1;
      end
    end
  end

  always_comb begin
    sym_cnt_d = sym_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      sym_cnt_d = '0;
      err_cnt_d = '0;
    end else if (bb_sym_vi) begin
      if (sym_cnt_q != C_CNT_MAX) sym_cnt_d = sym_cnt_q + C_CNT_ONE;
      if (!sym_match && (err_cnt_q != C_CNT_MAX)) err_cnt_d = err_cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      ref_q     <= C_LFSR_SEED;
      good_q    <= '0;
      bad_q     <= '0;
      sym_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      ref_q     <= ref_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      sym_cnt_q <= sym_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= sym_bad;
      if (!bb_sym_vi) begin
        state_q <= ST_IDLE;
        lock_q  <= 1'b0;
      end else begin
        case (state_q)
          // IDLE evaluates its first symbol exactly like HUNT.
          ST_IDLE, ST_HUNT: begin
            if (good_d >= LOCK_NUM) begin
              state_q <= ST_LOCK;
              lock_q  <= 1'b1;
            end else if (bad_d >= LOSS_NUM) begin
              state_q <= ST_FAIL;
              lock_q  <= 1'b0;
            end else begin
              state_q <= ST_HUNT;
              lock_q  <= 1'b0;
            end
          end
          ST_LOCK: begin
            if (bad_d >= LOSS_NUM) begin
              state_q <= ST_FAIL;
              lock_q  <= 1'b0;
            end else begin
              state_q <= ST_LOCK;
              lock_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_FAIL;
            lock_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign chk_lock  = lock_q;
  assign chk_err   = err_q;
  assign chk_state = state_q;
  assign sym_cnt   = sym_cnt_q;
  assign err_cnt   = err_cnt_q;

`ifdef BB_SYM_CHK_FIRST_ERR_EN
  logic                 fe_vld_q;
  logic [9:0]           fe_got_q, fe_exp_q;
  logic [CNT_WIDTH-1:0] fe_idx_q;

  // clr wins over a coincident mismatch, so that symbol is not captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_vld_q <= 1'b0;
      fe_got_q <= '0;
      fe_exp_q <= '0;
      fe_idx_q <= '0;
    end else if (clr) begin
      fe_vld_q <= 1'b0;
      fe_got_q <= '0;
      fe_exp_q <= '0;
      fe_idx_q <= '0;
    end else if (sym_bad && !fe_vld_q) begin
      fe_vld_q <= 1'b1;
      fe_got_q <= bb_sym_iq;
      fe_exp_q <= exp_sym;
      fe_idx_q <= sym_cnt_q;
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_got = fe_got_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_idx = fe_idx_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bb_sym_chk.sv
// ============================================================================
// tb_bb_sym_chk : randomized self-checking bench for bb_sym_chk against a
//                 behavioural reference model. Revision 1.0
// ============================================================================
`default_nettype none

module tb_bb_sym_chk;

  localparam int LOCK_N = 64;
  localparam int LOSS_N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  bb_sym_iq;
  logic        bb_sym_vi;
  logic        clr;

  logic        chk_lock, chk_err, chk_lock4, chk_err4;
  logic [1:0]  chk_state, chk_state4;
  logic [31:0] sym_cnt, err_cnt;
  logic [3:0]  sym_cnt4, err_cnt4;
`ifdef BB_SYM_CHK_FIRST_ERR_EN
  logic        fe_vld, fe_vld4;
  logic [9:0]  fe_got, fe_exp, fe_got4, fe_exp4;
  logic [31:0] fe_idx;
  logic [3:0]  fe_idx4;
`endif

  always #5 clk = ~clk;

  bb_sym_chk u_dut (
    .rst(rst), .clk(clk), .bb_sym_iq(bb_sym_iq), .bb_sym_vi(bb_sym_vi), .clr(clr),
    .chk_lock(chk_lock), .chk_err(chk_err), .chk_state(chk_state),
`ifdef BB_SYM_CHK_FIRST_ERR_EN
    .first_err_vld(fe_vld), .first_err_got(fe_got), .first_err_exp(fe_exp),
    .first_err_idx(fe_idx),
`endif
    .sym_cnt(sym_cnt), .err_cnt(err_cnt)
  );

  bb_sym_chk #(.CNT_WIDTH(4)) u_dut4 (
    .rst(rst), .clk(clk), .bb_sym_iq(bb_sym_iq), .bb_sym_vi(bb_sym_vi), .clr(clr),
    .chk_lock(chk_lock4), .chk_err(chk_err4), .chk_state(chk_state4),
`ifdef BB_SYM_CHK_FIRST_ERR_EN
    .first_err_vld(fe_vld4), .first_err_got(fe_got4), .first_err_exp(fe_exp4),
    .first_err_idx(fe_idx4),
`endif
    .sym_cnt(sym_cnt4), .err_cnt(err_cnt4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] lfsr_adv(input logic [39:0] x);
    return (x & 40'h7F_FFFF_FFBB) ^ (x << 1) ^ (x >> 1);
  endfunction

  // Reference model: plain integers, saturation via min().
  logic [39:0] m_ref;
  int          m_good, m_bad;
  logic [1:0]  m_state;
  bit          m_err, m_lock;
  longint      m_sym, m_errc, m_sym4, m_err4;
`ifdef BB_SYM_CHK_FIRST_ERR_EN
  bit          m_fev;
  logic [9:0]  m_fgot, m_fexp;
  longint      m_fidx;
`endif

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    m_ref = '1; m_good = 0; m_bad = 0; m_state = 2'd0; m_err = 0; m_lock = 0;
    m_sym = 0; m_errc = 0; m_sym4 = 0; m_err4 = 0;
`ifdef BB_SYM_CHK_FIRST_ERR_EN
    m_fev = 0; m_fgot = '0; m_fexp = '0; m_fidx = 0;
`endif
  endtask

  task automatic model_step(input logic v, input logic [9:0] s, input logic c);
    logic [9:0] e;
    bit ok;
    e  = m_ref[9:0] | 10'h021;
    ok = !v || (s == e);
`ifdef BB_SYM_CHK_FIRST_ERR_EN
    if (c) begin
      m_fev = 0; m_fgot = '0; m_fexp = '0; m_fidx = 0;
    end else if (v && !ok && !m_fev) begin
      m_fev = 1; m_fgot = s; m_fexp = e; m_fidx = m_sym;
    end
`endif
    if (c) begin
      m_sym = 0; m_errc = 0; m_sym4 = 0; m_err4 = 0;
    end else if (v) begin
      m_sym  = sat_inc(m_sym, 64'hFFFF_FFFF);
      m_sym4 = sat_inc(m_sym4, 15);
      if (!ok) begin
        m_errc = sat_inc(m_errc, 64'hFFFF_FFFF);
        m_err4 = sat_inc(m_err4, 15);
      end
    end
    if (!v) begin
      m_ref = '1; m_good = 0; m_bad = 0; m_state = 2'd0; m_err = 0;
    end else begin
      m_ref = lfsr_adv(m_ref);
      m_err = !ok;
      if (ok) begin m_good = int'(sat_inc(m_good, 65535)); m_bad = 0; end
      else    begin m_bad = int'(sat_inc(m_bad, 65535));   m_good = 0; end
      if (m_state != 2'd3) begin
        if (m_good >= LOCK_N)      m_state = 2'd2;
        else if (m_bad >= LOSS_N)  m_state = 2'd3;
        else if (m_state == 2'd0)  m_state = 2'd1;
      end
    end
    m_lock = (m_state == 2'd2);
  endtask

  task automatic compare_all();
    check("state",   chk_state,  m_state);
    check("lock",    chk_lock,   m_lock);
    check("err",     chk_err,    m_err);
    check("sym_cnt", sym_cnt,    m_sym);
    check("err_cnt", err_cnt,    m_errc);
    check("state4",  chk_state4, m_state);
    check("sym4",    sym_cnt4,   m_sym4);
    check("err4",    err_cnt4,   m_err4);
`ifdef BB_SYM_CHK_FIRST_ERR_EN
    check("fe_vld",  fe_vld, m_fev);
    check("fe_got",  fe_got, m_fgot);
    check("fe_exp",  fe_exp, m_fexp);
    check("fe_idx",  fe_idx, m_fidx);
`endif
  endtask

  task automatic step(input logic v, input logic [9:0] s, input logic c);
    bb_sym_vi = v; bb_sym_iq = s; clr = c;
    @(posedge clk);
    model_step(v, s, c);
    #1;
    compare_all();
  endtask

  // Stimulus generator, independent of the model's reference copy.
  logic [39:0] g;

  task automatic drive_sym(input bit corrupt, input logic [9:0] mask, input logic c);
    logic [9:0] s;
    s = g[9:0] | 10'h021;
    g = lfsr_adv(g);
    if (corrupt) s = s ^ mask;
    step(1'b1, s, c);
  endtask

  task automatic gap_cycle(input logic c);
    g = '1;
    step(1'b0, 10'($urandom), c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst;
    rst = 1'b1; bb_sym_vi = 1'b0; bb_sym_iq = '0; clr = 1'b0; g = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_all();

    repeat (10) gap_cycle(1'b0);

    // Clean stream of 100 symbols
    for (int i = 0; i < 100; i++) drive_sym(0, '0, 1'b0);
    check("clean_sym100", sym_cnt, 100);
    check("clean_err0",   err_cnt, 0);
    check("clean_lock",   chk_lock, 1);

    // Single flipped bit at symbol 10
    gap_cycle(1'b1);
    for (int i = 0; i < 100; i++) begin
      drive_sym(i == 10, 10'h008, 1'b0);
      if (i == 10) check("flip_pulse", chk_err, 1);
      if (i == 11) check("flip_pulse_end", chk_err, 0);
      if (i == 73) check("flip_nolock73", chk_lock, 0);
      if (i == 74) check("flip_lock74", chk_lock, 1);
    end
    check("flip_errcnt", err_cnt, 1);
`ifdef BB_SYM_CHK_FIRST_ERR_EN
    check("flip_fe_idx", fe_idx, 10);
    check("flip_fe_xor", fe_got ^ fe_exp, 10'h008);
`endif

    // Loss tolerance: 7 bad keeps lock, 8 bad fails
    drive_sym(0, '0, 1'b1);
    for (int i = 0; i < 7; i++) drive_sym(1, 10'h100, 1'b0);
    for (int i = 0; i < 5; i++) drive_sym(0, '0, 1'b0);
    check("loss7_lock", chk_lock, 1);
    check("loss7_err",  err_cnt, 7);
    for (int i = 0; i < 8; i++) begin
      drive_sym(1, 10'h001, 1'b0);
      if (i == 6) check("loss_state7", chk_state, 2);
    end
    check("loss8_state", chk_state, 3);
    check("loss8_lock",  chk_lock, 0);
    for (int i = 0; i < 5; i++) drive_sym(0, '0, 1'b0);
    check("fail_sticky", chk_state, 3);

    // Recovery after a one-cycle gap
    gap_cycle(1'b0);
    check("gap_idle", chk_state, 0);
    for (int i = 0; i < 64; i++) drive_sym(0, '0, 1'b0);
    check("relock", chk_lock, 1);

    // 4-bit counter saturation and clr
    gap_cycle(1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_sym(1, 10'h200, i == 18);
      if (i == 17) check("sat4_15", err_cnt4, 15);
      if (i == 18) check("sat4_clr", err_cnt4, 0);
    end
    check("sat4_after", err_cnt4, 1);

    // Asynchronous reset mid-stream
    gap_cycle(1'b0);
    for (int i = 0; i < 20; i++) drive_sym(0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #2 rst = 1'b0;
    g = '1;
    for (int i = 0; i < 5; i++) drive_sym(0, '0, 1'b0);
    check("post_rst_hunt", chk_state, 1);

    // Randomized traffic
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      int  r;
      bit  c;
      bit  bad;
      logic [9:0] mask;
      r    = $urandom_range(0, 99);
      c    = ($urandom_range(0, 99) == 0);
      mask = 10'd1 << $urandom_range(0, 9);
      if (r < 3) begin
        gap_cycle(c);
      end else begin
        bad = 0;
        if (burst > 0) begin bad = 1; burst--; end
        else if (r < 8) bad = 1;
        else if (r == 99) burst = $urandom_range(5, 12);
        drive_sym(bad, mask, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bb_sym_chk.md
# bb_sym_chk

Receive-side checker for the baseband test-symbol stream driven by the baseband symbol generator. It sits on the same 10-bit symbol/valid interface in the `clk` domain, downstream of the generator or on a loopback path. It regenerates the seeded 40-bit LFSR reference, compares every valid symbol against it, and reports lock, per-symbol errors and saturating symbol/error counts for bring-up and production self-test.

## Interface
- `LOCK_NUM`, default 16'd64: consecutive matching symbols needed to declare lock; legal range ≥1.
- `LOSS_NUM`, default 16'd8: consecutive mismatching symbols that force FAIL; legal range ≥1.
- `CNT_WIDTH`, default 32: width of `sym_cnt` and `err_cnt`.
- `rst` input 1: reset, asynchronous, active-high.
- `clk` input 1: clock, same clock as the generator's `clk`.
- `bb_sym_iq` input 10: received symbol.
- `bb_sym_vi` input 1: symbol valid.
- `clr` input 1: synchronous clear of `sym_cnt`, `err_cnt` and the FIRST_ERR capture.
- `chk_lock` output 1: high while in LOCK.
- `chk_err` output 1: one-cycle pulse per mismatched valid symbol.
- `chk_state` output 2: 0=IDLE, 1=HUNT, 2=LOCK, 3=FAIL.
- `sym_cnt` output CNT_WIDTH: valid symbols seen, saturating.
- `err_cnt` output CNT_WIDTH: mismatched symbols, saturating.

## Operation
- Reference register `ref_lfsr[39:0]` is all ones on reset. It is reloaded to all ones on any cycle with `bb_sym_vi`=0.
- With `bb_sym_vi`=1, `ref_lfsr` advances as `next = (ref & 40'h7FFFFFFFBB) ^ (ref << 1) ^ (ref >> 1)`.
- Expected symbol is `ref_lfsr[9:0] | 10'h021`. The first valid symbol after any valid gap is therefore 10'h3FF.
- Match means all 10 bits are equal. The forced bits 0 and 5 are compared as well.
- Run counters: `good_run` and `bad_run`, 16 bits each, saturating.
  - On a match: `good_run` increments and `bad_run` clears.
  - On a mismatch: `bad_run` increments and `good_run` clears.
  - When `bb_sym_vi`=0, both runs clear.
- State machine, updated from the post-update run values:
  - IDLE → HUNT on any valid symbol; that symbol is checked.
  - HUNT → LOCK when `good_run` reaches LOCK_NUM.
  - HUNT or LOCK → FAIL when `bad_run` reaches LOSS_NUM.
  - FAIL stays FAIL while valid remains high. The reference cannot resynchronise without a reseed.
  - Any state → IDLE on a cycle with `bb_sym_vi`=0. This takes priority over all other transitions.
- LOCK_NUM and LOSS_NUM reached on the same symbol cannot happen, because the runs are exclusive.
- Counters:
  - `sym_cnt` increments on every valid symbol, in every state.
  - `err_cnt` increments on every mismatch, in every state including FAIL.
  - Both hold at all-ones once saturated.
- `clr`: counters load 0 on a `clr` cycle, and the symbol sampled in that cycle is not counted. `clr` does not affect the state, the runs or `ref_lfsr`.

## Timing
- All outputs are registered. Reset values: `chk_lock`=0, `chk_err`=0, `chk_state`=0, `sym_cnt`=0, `err_cnt`=0, capture outputs 0.
- Latency: a symbol sampled at edge k is reflected in `chk_err`, the counters, `chk_state` and `chk_lock` right after edge k.
- `chk_lock` rises right after the edge sampling the LOCK_NUM-th consecutive match. It falls right after the LOSS_NUM-th consecutive mismatch, or after the first invalid cycle.
- Reset asserted mid-stream returns every register to its reset value immediately. The checker resumes from IDLE on the first valid symbol after release.

## Configuration
- Macro `BB_SYM_CHK_FIRST_ERR_EN`.
- Defined: four extra outputs are compiled in.
  - `first_err_vld` (1 bit) is set on the first mismatch since reset or `clr`.
  - At the same edge it latches `first_err_got[9:0]`, `first_err_exp[9:0]`, and `first_err_idx[CNT_WIDTH-1:0]`.
  - `first_err_idx` is the `sym_cnt` value before the increment, i.e. a 0-based index.
  - All four hold until `clr` or reset.
  - A `clr` coinciding with a mismatch clears the capture; it is not re-captured that cycle.
- Undefined: the ports and the capture logic are absent. All other behaviour is identical.

## Test plan
- Reset, then hold `bb_sym_vi`=0 for 10 cycles → `chk_state`=0, all outputs 0, no `chk_err`.
- Drive 100 symbols from a reference generator after `bb_sym_vi` rises, first symbol 10'h3FF → `chk_lock` rises after symbol 64, `sym_cnt`=100, `err_cnt`=0.
- Flip bit 3 of symbol 10 (0-based) in a clean stream → single `chk_err` pulse one cycle later, `err_cnt`=1, lock delayed to after symbol 74. With the macro defined: `first_err_idx`=10, and `first_err_got` ^ `first_err_exp` = 10'h008.
- After lock, corrupt 7 consecutive symbols then resume → remains LOCK, `err_cnt`=7. Corrupt 8 consecutive → `chk_state`=3 and `chk_lock`=0 right after the 8th.
- From FAIL, drop `bb_sym_vi` for 1 cycle, then restart the generator from seed → IDLE for that cycle, first symbol 10'h3FF matches, lock reacquired after 64 symbols.
- With CNT_WIDTH=4: stream 20 all-bad symbols with `clr` pulsed on symbol 18 → `err_cnt` saturates at 15, is 0 after the clr edge, and reads 1 after symbol 19.
